tt_um_kalman_filter: RTL and testbench
======================================

// Module: tt_um_kalman_filter
// PURPOSE
//  Scalar (1-D) Kalman filter tile for a TinyTapeout slot. Filters a stream of
//  8-bit measurements and presents the current state estimate on uo_out. Process
//  noise Q and measurement noise R are runtime-configurable over uio_in.
//  Iterative gain division: one measurement update every 12 cycles.
// PARAMETERS
//  none (all widths fixed: x Q8.8 16b, P Q8.8 16b, Q/R Q4.4 8b, K 0.8 fraction)
// PORTS
//  clk      in   1  system clock, all state on rising edge
//  rst_n    in   1  reset; asynchronous, active-high (asserted = 1)
//  ena      in   1  slot enable; ignored
//  ui_in    in   8  measurement z (unsigned integer) / config data
//  uio_in   in   8  [0]=meas_valid [1]=cfg_wr [3:2]=cfg_sel; [7:4] ignored
//  uo_out   out  8  estimate = x[15:8] (truncated integer part)
//  uio_out  out  8  [4]=busy [5]=est_valid; all other bits 0
//  uio_oe   out  8  constant 8'b0011_0000
// BEHAVIOUR
//  Reset values: x=0, P=16'hFFFF, Q=8'd1, R=8'd16, state IDLE; uo_out=0, busy=0, est_valid=0.
//  FSM: IDLE -> PREDICT (1 cyc) -> DIVIDE (9 cyc) -> UPDATE (1 cyc) -> DONE (1 cyc) -> IDLE.
//  IDLE, edge E0: cfg_wr=1 -> config write (priority over meas_valid, measurement dropped);
//   else meas_valid=1 -> latch z, enter PREDICT. busy=1 in all states except IDLE.
//  Config (IDLE only): sel 00 -> Q=ui_in; 01 -> R=ui_in; 10 -> x={ui_in,8'h00}, P=16'hFFFF;
//   11 -> no effect. cfg_wr / meas_valid while busy are ignored (not queued).
//  PREDICT: P' = min(P + (Q<<4), 16'hFFFF); D = P' + (R<<4) (17 bit).
//  DIVIDE: restoring division, 1 quotient bit per cycle, 9 bits: K9 = floor(256*P'/D);
//   K = min(K9,255); D==0 -> K=0.
//  UPDATE: e = {z,8'h00} - x (signed 17b); x = clamp(x + ((K*e) >>> 8), 0, 16'hFFFF)
//   (arithmetic shift, floor); P = ((256-K)*P') >> 8. est_valid=1 in UPDATE->DONE cycle.
//  Timing: meas sampled at E0; x/P/uo_out update at E11; est_valid high E11..E12 exactly
//   one cycle; busy low after E12; next measurement accepted at E13 or later.
//  uo_out = x[15:8] at all times (follows config writes to x immediately).
//  Reset asserted mid-operation: abort, all registers to reset values asynchronously.
// TESTING
//  1 Reset -> uo_out=0x00, uio_oe=0x30, uio_out=0x00, busy=0.
//  2 After reset, z=100 with meas_valid -> K=255, x=25500 (0x639C), uo_out=99, P=255;
//    est_valid pulses 1 cycle at E11, busy high E1..E12.
//  3 Write R=0 (sel 01), then cfg x=10 (sel 10), z=200 -> K clamped 255,
//    uo_out=199 (x=0xC7xx); verify no K overflow to 0.
//  4 Assert meas_valid and cfg_wr every cycle while busy -> ignored: Q/R/x
//    unchanged, exactly one est_valid per accepted measurement.
//  5 Q=0, R=255, 30 samples z=50 -> uo_out converges to 49..50, P monotonic non-increasing.
//  6 Reset pulse at E5 of an update -> busy=0, uo_out=0, P=0xFFFF immediately; next
//    measurement behaves as scenario 2.

Source files
------------

// File: rtl/tt_um_kalman_filter.sv
// Scalar Kalman filter tile: 8-bit measurements in, Q8.8 state estimate out.
// A measurement update takes 12 cycles because the gain is found by a 9-step restoring divide.
module tt_um_kalman_filter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREDICT = 3'd1,
    ST_DIVIDE  = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t      state_r, next_state_s;
  logic [15:0] x_r, p_r, pp_r;
  logic [7:0]  q_r, r_r, z_r;
  logic [16:0] d_r;
  logic [17:0] rem_r;
  logic [8:0]  quo_r;
  logic [3:0]  cnt_r;
  logic        busy_r, est_valid_r;

  logic        meas_valid_s, cfg_wr_s;
  logic [1:0]  cfg_sel_s;
  logic [16:0] p_sum_s, d_s;
  logic [15:0] p_pred_s;
  logic        rem_ge_s;
  logic [17:0] rem_diff_s;
  logic [7:0]  k_s;
  logic [8:0]  k_inv_s;
  logic signed [16:0] e_s;
  logic signed [25:0] prod_s, delta_s;
  logic signed [26:0] x_sum_s;
  logic [15:0] x_new_s;
  logic [24:0] p_prod_s;
  logic        unused_s;

  assign meas_valid_s = uio_in[0];
  assign cfg_wr_s     = uio_in[1];
  assign cfg_sel_s    = uio_in[3:2];
  assign unused_s     = &{1'b0, ena, uio_in[7:4]};

  assign uo_out  = x_r[15:8];
  assign uio_out = {2'b00, est_valid_r, busy_r, 4'b0000};
  assign uio_oe  = 8'b0011_0000;

  // State register plus registered status flags derived from the next state
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      est_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      busy_r      <= (next_state_s != ST_IDLE);
      est_valid_r <= (next_state_s == ST_DONE);
    end
  end

  // Next-state sequencing; config writes win over measurements in IDLE
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!cfg_wr_s && meas_valid_s) next_state_s = ST_PREDICT;
        else                           next_state_s = ST_IDLE;
      end
      ST_PREDICT: next_state_s = ST_DIVIDE;
      ST_DIVIDE: begin
        if (cnt_r == 4'd8) next_state_s = ST_UPDATE;
        else               next_state_s = ST_DIVIDE;
      end
      ST_UPDATE: next_state_s = ST_DONE;
      ST_DONE:   next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Datapath arithmetic: predict, one divide step, gain clamp and corrections
  always_comb begin
    p_sum_s  = {1'b0, p_r} + {5'd0, q_r, 4'h0};
    p_pred_s = p_sum_s[16] ? 16'hFFFF : p_sum_s[15:0];
    d_s      = {1'b0, p_pred_s} + {5'd0, r_r, 4'h0};

    rem_ge_s   = (rem_r >= {1'b0, d_r});
    rem_diff_s = rem_r - {1'b0, d_r};

    // A zero denominator would divide to all ones; force a zero gain instead
    if (d_r == 17'd0)   k_s = 8'd0;
    else if (quo_r[8])  k_s = 8'd255;
    else                k_s = quo_r[7:0];
    k_inv_s = 9'd256 - {1'b0, k_s};

    e_s     = $signed({1'b0, z_r, 8'h00}) - $signed({1'b0, x_r});
    prod_s  = $signed({1'b0, k_s}) * e_s;
    delta_s = prod_s >>> 8;
    x_sum_s = $signed({11'd0, x_r}) + $signed({delta_s[25], delta_s});
    if (x_sum_s < 27'sd0)          x_new_s = 16'h0000;
    else if (x_sum_s > 27'sd65535) x_new_s = 16'hFFFF;
    else                           x_new_s = x_sum_s[15:0];

    p_prod_s = {16'd0, k_inv_s} * {9'd0, pp_r};
  end

  // Filter state, configuration and divider registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      x_r   <= 16'h0000;
      p_r   <= 16'hFFFF;
      q_r   <= 8'd1;
      r_r   <= 8'd16;
      z_r   <= 8'd0;
      pp_r  <= 16'h0000;
      d_r   <= 17'd0;
      rem_r <= 18'd0;
      quo_r <= 9'd0;
      cnt_r <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cfg_wr_s) begin
            case (cfg_sel_s)
              2'b00: q_r <= ui_in;
              2'b01: r_r <= ui_in;
              2'b10: begin
                x_r <= {ui_in, 8'h00};
                p_r <= 16'hFFFF;
              end
              default: ;
            endcase
          end else if (meas_valid_s) begin
            z_r <= ui_in;
          end
        end
        ST_PREDICT: begin
          pp_r  <= p_pred_s;
          d_r   <= d_s;
          rem_r <= {2'b00, p_pred_s};
          quo_r <= 9'd0;
          cnt_r <= 4'd0;
        end
        ST_DIVIDE: begin
          cnt_r <= cnt_r + 4'd1;
          if (rem_ge_s) begin
            quo_r <= {quo_r[7:0], 1'b1};
            rem_r <= {rem_diff_s[16:0], 1'b0};
          end else begin
            quo_r <= {quo_r[7:0], 1'b0};
            rem_r <= {rem_r[16:0], 1'b0};
          end
        end
        ST_UPDATE: begin
          x_r <= x_new_s;
          p_r <= p_prod_s[23:8];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_kalman_filter.sv
// Directed bench for the scalar Kalman tile; expected values are worked out by hand
// from the filter equations (gain, error term, covariance) for each vector.
module tb_tt_um_kalman_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena = 1'b1;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_cmp = 0;
  int n_err = 0;
  logic [12:0] busy_vec, est_vec;
  int est_cnt;

  tt_um_kalman_filter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [7:0] data);
    @(negedge clk);
    ui_in  = data;
    uio_in = {4'b0000, sel, 2'b10};
    @(posedge clk);
    #1;
    uio_in = 8'h00;
  endtask

  // One measurement; records busy/est_valid just after E0..E12. With spam set,
  // meas_valid and a config write of x=0x55 are held during the whole busy window.
  task automatic measure(input logic [7:0] z, input bit spam);
    @(negedge clk);
    ui_in  = z;
    uio_in = 8'h01;
    @(posedge clk);
    #1;
    busy_vec[0] = uio_out[4];
    est_vec[0]  = uio_out[5];
    if (spam) begin
      ui_in  = 8'h55;
      uio_in = 8'b0000_1011;
    end else begin
      uio_in = 8'h00;
    end
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      busy_vec[k] = uio_out[4];
      est_vec[k]  = uio_out[5];
    end
    uio_in  = 8'h00;
    est_cnt = 0;
    for (int k = 0; k <= 12; k++) est_cnt += int'(est_vec[k]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_uo", uo_out, 32'h00);
    check_eq("reset_oe", uio_oe, 32'h30);
    check_eq("reset_uio_out", uio_out, 32'h00);
    @(negedge clk);
    rst_n = 1'b0;

    // K=255, x=0x639C
    measure(8'd100, 1'b0);
    check_eq("s2_uo", uo_out, 32'd99);
    check_eq("s2_busy_profile", busy_vec, 32'h0FFF);
    check_eq("s2_est_profile", est_vec, 32'h0800);
    check_eq("s2_idle_flags", uio_out, 32'h00);

    // R=0 makes D==P' so the gain quotient is 256 and must clamp to 255
    cfg_write(2'b01, 8'd0);
    cfg_write(2'b10, 8'd10);
    check_eq("s3_cfg_x", uo_out, 32'd10);
    measure(8'd200, 1'b0);
    check_eq("s3_uo", uo_out, 32'd199);
    cfg_write(2'b11, 8'hAA);
    check_eq("s3_sel11_noop", uo_out, 32'd199);

    // Writes and measurements while busy are dropped
    do_reset();
    measure(8'd100, 1'b1);
    check_eq("s4_uo", uo_out, 32'd99);
    check_eq("s4_est_count", est_cnt, 32'd1);
    check_eq("s4_busy_profile", busy_vec, 32'h0FFF);

    // Convergence with Q=0, R=255: x = 12000, 12400, 12532, 12599 ...
    do_reset();
    cfg_write(2'b00, 8'd0);
    cfg_write(2'b01, 8'd255);
    measure(8'd50, 1'b0);
    check_eq("s5_step1", uo_out, 32'd46);
    measure(8'd50, 1'b0);
    check_eq("s5_step2", uo_out, 32'd48);
    measure(8'd50, 1'b0);
    check_eq("s5_step3", uo_out, 32'd48);
    measure(8'd50, 1'b0);
    check_eq("s5_step4", uo_out, 32'd49);
    for (int i = 4; i < 30; i++) measure(8'd50, 1'b0);
    check_eq("s5_converged", 32'((uo_out >= 8'd49) && (uo_out <= 8'd50)), 32'd1);

    // Asynchronous reset in the middle of an update
    @(negedge clk);
    ui_in  = 8'd200;
    uio_in = 8'h01;
    @(posedge clk);
    #1;
    uio_in = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    check_eq("s6_busy_before", uio_out[4], 32'd1);
    rst_n = 1'b1;
    #1;
    check_eq("s6_busy_abort", uio_out[4], 32'd0);
    check_eq("s6_uo_abort", uo_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    measure(8'd100, 1'b0);
    check_eq("s6_after_uo", uo_out, 32'd99);
    check_eq("s6_after_est", est_vec, 32'h0800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
